// File: rtl/seq_detect_pkg.sv
// Shared types and default sizing for the serial pattern-detect scheduler.
package seq_detect_pkg;

  localparam int WORD_W_DEF = 8;
  localparam int PAT_W_DEF  = 4;
  localparam int CNT_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/seq_pat_window.sv
// Sliding PAT_W-bit window with fill tracking and pattern compare.
// Optional macro SEQ_DETECT_NO_OVERLAP_EN: a match clears the window so
// the next match needs PAT_W fresh bits. Undefined: window keeps sliding.
module seq_pat_window
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             match
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  win_r;
  logic [PAT_W-1:0]  win_next_s;
  logic [FILL_W-1:0] fill_r;
  logic [FILL_W-1:0] fill_next_s;

  // Next window/fill as if the incoming bit were already shifted in.
  always_comb begin
    win_next_s = {win_r[PAT_W-2:0], bit_in};
    if (fill_r == FILL_FULL) begin
      fill_next_s = fill_r;
    end else begin
      fill_next_s = fill_r + FILL_W'(1);
    end
  end

  // The match includes the bit being shifted in this cycle.
  assign match = shift_en && (fill_next_s == FILL_FULL) && (win_next_s == pattern);

  // Window and fill state: cleared per request, advanced on each shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_r  <= '0;
      fill_r <= '0;
    end else if (clear) begin
      win_r  <= '0;
      fill_r <= '0;
    end else if (shift_en) begin
`ifdef SEQ_DETECT_NO_OVERLAP_EN
      if (match) begin
        win_r  <= '0;
        fill_r <= '0;
      end else begin
        win_r  <= win_next_s;
        fill_r <= fill_next_s;
      end
`else
      win_r  <= win_next_s;
      fill_r <= fill_next_s;
`endif
    end
  end

endmodule

// File: rtl/seq_detect_sched.sv
// Two-requester round-robin front end sharing one serial pattern detector.
// Words are shifted MSB-first; the match count returns with the requester ID.
// Optional macro SEQ_DETECT_NO_OVERLAP_EN selects non-overlapping detection.
module seq_detect_sched
  import seq_detect_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int PAT_W  = PAT_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [WORD_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [WORD_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic [PAT_W-1:0]  pattern,
  output logic              resp_valid,
  output logic              resp_id,
  output logic [CNT_W-1:0]  resp_count,
  input  logic              resp_ready,
  output logic              busy
);

  localparam int IDX_W = $clog2(WORD_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

  // Elaboration-time guard: the counter must hold the maximum match count.
  if ((WORD_W - PAT_W + 1) >= (1 << CNT_W)) begin : g_cnt_w_check
    $error("CNT_W too narrow for WORD_W-PAT_W+1 matches");
  end
  if ((PAT_W < 2) || (PAT_W > WORD_W)) begin : g_pat_w_check
    $error("PAT_W must be in 2..WORD_W");
  end

  state_t            state_r;
  logic [WORD_W-1:0] shreg_r;
  logic [PAT_W-1:0]  pat_r;
  logic [IDX_W-1:0]  bit_idx_r;
  logic [CNT_W-1:0]  cnt_r;
  req_id_t           last_grant_r;

  req_id_t           grant_s;
  logic              grant_vld_s;
  logic              accept_s;
  logic [WORD_W-1:0] sel_data_s;
  logic              match_s;
  logic [CNT_W-1:0]  cnt_next_s;

  // Round-robin grant: a lone requester wins, a tie goes away from last_grant.
  always_comb begin
    grant_s     = 1'b0;
    grant_vld_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_vld_s = 1'b1;
      grant_s     = ~last_grant_r;
    end else if (req0_valid) begin
      grant_vld_s = 1'b1;
      grant_s     = 1'b0;
    end else if (req1_valid) begin
      grant_vld_s = 1'b1;
      grant_s     = 1'b1;
    end else begin
      grant_vld_s = 1'b0;
      grant_s     = 1'b0;
    end
  end

  // Ready is offered only in IDLE and is held low while reset is asserted.
  assign accept_s   = reset && (state_r == IDLE) && grant_vld_s;
  assign req0_ready = accept_s && (grant_s == 1'b0);
  assign req1_ready = accept_s && (grant_s == 1'b1);
  assign sel_data_s = grant_s ? req1_data : req0_data;
  assign cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, match_s};

  seq_pat_window #(
    .PAT_W (PAT_W)
  ) u_window (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept_s),
    .shift_en (state_r == SHIFT),
    .bit_in   (shreg_r[WORD_W-1]),
    .pattern  (pat_r),
    .match    (match_s)
  );

  // Control FSM: accept, shift WORD_W bits, hold the result until taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      shreg_r      <= '0;
      pat_r        <= '0;
      bit_idx_r    <= '0;
      cnt_r        <= '0;
      last_grant_r <= 1'b1;
      resp_valid   <= 1'b0;
      resp_id      <= 1'b0;
      resp_count   <= '0;
      busy         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            shreg_r      <= sel_data_s;
            pat_r        <= pattern;
            bit_idx_r    <= '0;
            cnt_r        <= '0;
            resp_id      <= grant_s;
            last_grant_r <= grant_s;
            busy         <= 1'b1;
            state_r      <= SHIFT;
          end
        end
        SHIFT: begin
          shreg_r <= {shreg_r[WORD_W-2:0], 1'b0};
          cnt_r   <= cnt_next_s;
          if (bit_idx_r == IDX_LAST) begin
            resp_count <= cnt_next_s;
            resp_valid <= 1'b1;
            state_r    <= RESP;
          end else begin
            bit_idx_r <= bit_idx_r + IDX_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state_r    <= IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_sched.sv
// Directed self-checking bench for seq_detect_sched (WORD_W=8, PAT_W=4, CNT_W=4).
module tb_seq_detect_sched;

`ifdef SEQ_DETECT_NO_OVERLAP_EN
  localparam logic [3:0] EXP_AA = 4'd2;
  localparam logic [3:0] EXP_FF = 4'd2;
  localparam logic [3:0] EXP_00 = 4'd2;
`else
  localparam logic [3:0] EXP_AA = 4'd3;
  localparam logic [3:0] EXP_FF = 4'd5;
  localparam logic [3:0] EXP_00 = 4'd5;
`endif

  logic       clk;
  logic       reset;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic [3:0] pattern;
  logic       resp_valid;
  logic       resp_id;
  logic [3:0] resp_count;
  logic       resp_ready;
  logic       busy;

  int pass_cnt;
  int total_cnt;

  seq_detect_sched #(
    .WORD_W (8),
    .PAT_W  (4),
    .CNT_W  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .pattern    (pattern),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_count (resp_count),
    .resp_ready (resp_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until resp_valid; returns edges taken, or -1 if the budget expires.
  task automatic wait_resp(output int lat);
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (resp_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) step();
    total_cnt++;
    if ({req1_ready, req0_ready} !== 2'b00) $display("FAIL reset_ready: got %b expected 00", {req1_ready, req0_ready});
    else pass_cnt++;
    total_cnt++;
    if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b expected 0", resp_valid);
    else pass_cnt++;
    total_cnt++;
    if (resp_id !== 1'b0) $display("FAIL reset_resp_id: got %b expected 0", resp_id);
    else pass_cnt++;
    total_cnt++;
    if (resp_count !== 4'd0) $display("FAIL reset_resp_count: got %0d expected 0", resp_count);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
    else pass_cnt++;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b1;
    step();
  endtask

  task automatic test_tie();
    int lat;
    pattern = 4'b1111;
    req0_data = 8'hF0;
    req1_data = 8'h0F;
    resp_ready = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    total_cnt++;
    if ({req1_ready, req0_ready} !== 2'b01) $display("FAIL tie_first_grant: got %b expected 01", {req1_ready, req0_ready});
    else pass_cnt++;
    step();
    req0_valid = 1'b0;
    wait_resp(lat);
    total_cnt++;
    if (lat !== 8) $display("FAIL tie_latency0: got %0d expected 8", lat);
    else pass_cnt++;
    total_cnt++;
    if ({resp_id, resp_count} !== {1'b0, 4'd1}) $display("FAIL tie_resp0: got id %b count %0d expected id 0 count 1", resp_id, resp_count);
    else pass_cnt++;
    total_cnt++;
    if (req1_ready !== 1'b0) $display("FAIL tie_ready_in_resp: got %b expected 0", req1_ready);
    else pass_cnt++;
    step();
    total_cnt++;
    if (req1_ready !== 1'b1) $display("FAIL tie_second_grant: got %b expected 1", req1_ready);
    else pass_cnt++;
    step();
    req1_valid = 1'b0;
    wait_resp(lat);
    total_cnt++;
    if ({resp_id, resp_count} !== {1'b1, 4'd1}) $display("FAIL tie_resp1: got id %b count %0d expected id 1 count 1", resp_id, resp_count);
    else pass_cnt++;
    step();
  endtask

  task automatic test_fairness();
    int   lat;
    logic exp_id;
    pattern = 4'b1111;
    req0_data = 8'hF0;
    req1_data = 8'hFF;
    resp_ready = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_id = (i % 2 == 1);
      #1;
      total_cnt++;
      if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) $display("FAIL fair_grant%0d: got %b expected id %b", i, {req1_ready, req0_ready}, exp_id);
      else pass_cnt++;
      step();
      wait_resp(lat);
      total_cnt++;
      if ({resp_id, resp_count} !== {exp_id, (exp_id ? EXP_FF : 4'd1)}) $display("FAIL fair_resp%0d: got id %b count %0d lat %0d", i, resp_id, resp_count, lat);
      else pass_cnt++;
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_overlap();
    int lat;
    pattern = 4'b1010;
    req0_data = 8'hAA;
    resp_ready = 1'b1;
    req0_valid = 1'b1;
    #1;
    total_cnt++;
    if ({req1_ready, req0_ready} !== 2'b01) $display("FAIL ovl_ready: got %b expected 01", {req1_ready, req0_ready});
    else pass_cnt++;
    step();
    req0_valid = 1'b0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL ovl_busy: got %b expected 1", busy);
    else pass_cnt++;
    wait_resp(lat);
    total_cnt++;
    if (lat !== 8) $display("FAIL ovl_latency: got %0d expected 8", lat);
    else pass_cnt++;
    total_cnt++;
    if (resp_id !== 1'b0) $display("FAIL ovl_id: got %b expected 0", resp_id);
    else pass_cnt++;
    total_cnt++;
    if (resp_count !== EXP_AA) $display("FAIL ovl_count: got %0d expected %0d", resp_count, EXP_AA);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({resp_valid, busy} !== 2'b00) $display("FAIL ovl_return_idle: got %b expected 00", {resp_valid, busy});
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int lat;
    pattern = 4'b1010;
    req0_data = 8'hAA;
    req1_data = 8'h0F;
    resp_ready = 1'b0;
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    wait_resp(lat);
    total_cnt++;
    if (lat !== 8) $display("FAIL bp_latency: got %0d expected 8", lat);
    else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      total_cnt++;
      if ({resp_valid, resp_id, resp_count} !== {1'b1, 1'b0, EXP_AA}) $display("FAIL bp_hold%0d: got v %b id %b count %0d", c, resp_valid, resp_id, resp_count);
      else pass_cnt++;
      total_cnt++;
      if ({req1_ready, req0_ready, busy} !== 3'b001) $display("FAIL bp_ready_busy%0d: got %b expected 001", c, {req1_ready, req0_ready, busy});
      else pass_cnt++;
      step();
    end
    resp_ready = 1'b1;
    step();
    total_cnt++;
    if ({resp_valid, req1_ready} !== 2'b01) $display("FAIL bp_release: got %b expected 01", {resp_valid, req1_ready});
    else pass_cnt++;
    step();
    req1_valid = 1'b0;
    wait_resp(lat);
    total_cnt++;
    if ({resp_id, resp_count} !== {1'b1, 4'd0}) $display("FAIL bp_next: got id %b count %0d expected id 1 count 0", resp_id, resp_count);
    else pass_cnt++;
    step();
  endtask

  task automatic test_pattern_change();
    int lat;
    pattern = 4'b1010;
    req0_data = 8'hAA;
    resp_ready = 1'b1;
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    pattern = 4'b0000;
    wait_resp(lat);
    total_cnt++;
    if (resp_count !== EXP_AA) $display("FAIL patchg_count: got %0d expected %0d", resp_count, EXP_AA);
    else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid();
    int lat;
    int spurious;
    pattern = 4'b1111;
    req0_data = 8'hFF;
    resp_ready = 1'b1;
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    repeat (4) step();
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({resp_valid, resp_id, resp_count, busy, req0_ready, req1_ready} !== 9'd0) $display("FAIL midrst_outputs: got v %b id %b count %0d busy %b", resp_valid, resp_id, resp_count, busy);
    else pass_cnt++;
    step();
    reset = 1'b1;
    spurious = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (resp_valid === 1'b1) spurious++;
    end
    total_cnt++;
    if (spurious !== 0) $display("FAIL midrst_no_resp: got %0d resp cycles expected 0", spurious);
    else pass_cnt++;
    pattern = 4'b0000;
    req0_data = 8'h00;
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    wait_resp(lat);
    total_cnt++;
    if (lat !== 8) $display("FAIL midrst_latency: got %0d expected 8", lat);
    else pass_cnt++;
    total_cnt++;
    if ({resp_id, resp_count} !== {1'b0, EXP_00}) $display("FAIL midrst_count: got id %b count %0d expected id 0 count %0d", resp_id, resp_count, EXP_00);
    else pass_cnt++;
    step();
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    reset = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data = 8'h00;
    req1_data = 8'h00;
    pattern = 4'b0000;
    resp_ready = 1'b0;
    test_reset();
    test_tie();
    test_fairness();
    test_overlap();
    test_backpressure();
    test_pattern_change();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seq_detect_sched.md
Name: seq_detect_sched

Overview:
- Shared serial pattern-detection engine with a two-requester round-robin front end.
- Each requester hands over a parallel word. The block serializes it MSB-first through a configurable pattern window, counts matches, and returns the count with the requester ID.
- Sits between processor-side clients and the serial detect datapath. Sequences the single detector so it is never used by two clients at once.

Parameters:
- WORD_W, 8, bits per request word (>= PAT_W).
- PAT_W, 4, pattern length in bits (2..WORD_W).
- CNT_W, 4, match-count width; must hold WORD_W-PAT_W+1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has a word
- req0_data  in  WORD_W  requester 0 word
- req0_ready  out  1  requester 0 accepted this cycle
- req1_valid  in  1  requester 1 has a word
- req1_data  in  WORD_W  requester 1 word
- req1_ready  out  1  requester 1 accepted this cycle
- pattern  in  PAT_W  pattern to detect, sampled at accept
- resp_valid  out  1  result available
- resp_id  out  1  requester served (0/1)
- resp_count  out  CNT_W  number of matches in word
- resp_ready  in  1  consumer takes result
- busy  out  1  high in SHIFT or RESP

Behaviour:
- Reset (reset=0, async) forces:
  - state=IDLE; req*_ready=0; resp_valid=0; resp_id=0; resp_count=0; busy=0.
  - last_grant=1, so req0 wins the first tie.
  - Shift register, window and counter cleared.
- States:
  - IDLE: no word in progress.
  - SHIFT: bit_idx runs 0..WORD_W-1.
  - RESP: result held for the consumer.
- IDLE:
  - Grant logic is combinational on valid. If only one requester is valid, it is granted. If both are valid, grant goes to the requester != last_grant.
  - reqN_ready=1 for the granted requester only, in IDLE only.
  - At the handshake edge: capture data into the shift register; latch pattern; clear window, valid-bit count and match counter; record resp_id and last_grant; go to SHIFT.
- SHIFT, once per cycle:
  - Shift the MSB of the word into the window LSB.
  - Increment the fill count, saturating at PAT_W.
  - If fill count (including this bit) >= PAT_W and window == latched pattern, increment match_count.
  - After WORD_W shifted bits, go to RESP.
  - Matches never span words; the window is cleared per request.
- RESP:
  - resp_valid=1; resp_count and resp_id stable until resp_ready=1.
  - On the resp_valid && resp_ready edge, go to IDLE.
  - Both req*_ready stay 0 throughout.
- Latency:
  - resp_valid rises exactly WORD_W cycles after the accept edge.
  - Minimum turnaround is WORD_W+2 cycles per word when resp_ready is tied high: accept, WORD_W shifts, 1 RESP cycle.
- Simultaneous events:
  - A requester dropping valid in IDLE before the handshake is not an error.
  - A new valid arriving during SHIFT/RESP waits.
  - pattern changes after accept are ignored.
- Reset mid-SHIFT or mid-RESP: the in-flight word is discarded, no response is issued, and the next request starts fresh.
- Count arithmetic is unsigned. It cannot overflow given the CNT_W constraint; this is checked by a static assertion.

Optional Feature:
- Macro: SEQ_DETECT_NO_OVERLAP_EN.
- When defined, detection is non-overlapping: after a match the window and fill count clear, so the next match needs PAT_W fresh bits.
- When undefined, detection is overlapping: the window keeps sliding after a match.

Decomposition:
- Shared package seq_detect_pkg holds:
  - state enum (IDLE, SHIFT, RESP);
  - default WORD_W/PAT_W/CNT_W constants;
  - requester-ID typedef.
- One sub-module, seq_pat_window:
  - Holds the PAT_W window, fill count and compare.
  - Inputs: clear, shift_en, bit_in, pattern.
  - Output: match pulse.
  - The non-overlap macro is handled inside it.

Test Plan:
- Overlap, single requester: pattern=4'b1010, req0 word 8'hAA, resp_ready=1 → resp_valid 8 cycles after accept, resp_id=0, resp_count=3. With SEQ_DETECT_NO_OVERLAP_EN defined, resp_count=2.
- Tie after reset: req0 (8'hF0) and req1 (8'h0F) valid together, pattern=4'b1111 → req0 served first with count=1, then req1 with count=1, resp_id sequence 0,1.
- Fairness: both requesters held valid for 4 words → grants alternate 0,1,0,1; neither starves.
- Backpressure: resp_ready=0 for 3 cycles in RESP → resp_valid/resp_count/resp_id held; req*_ready=0; busy=1. Accept proceeds after release.
- Pattern change after accept: pattern switches 4'b1010→4'b0000 one cycle after accept of 8'hAA → count=3.
- Reset mid-SHIFT: assert reset at bit 4 of 8'hFF → all outputs 0 immediately, no response. Next request 8'h00 with pattern 4'b0000 → count=5.
